// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer
//   Accepts ALSU commands over valid/ready, buffers them in a DEPTH-entry FIFO
//   and drives each one onto the registered ALSU input bus for 1+cmd_repeat
//   cycles. A delay line matched to the ALSU latency reports when the ALSU
//   output reflects an issued op (res_valid) and whether the ALSU should
//   flag it invalid (exp_invalid).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             sync clear of FIFO, hold counter and bus
//   cmd_*             command handshake and payload
//   opcode..direction registered ALSU bus
//   issue_valid       bus carries a real op this cycle
//   res_valid         ALSU out reflects an issued op
//   exp_invalid       that op is invalid by ALSU rules
//   issued_cnt        saturating count of issue cycles
//   fifo_count        registered FIFO occupancy
module alsu_cmd_issuer #(
   parameter int DEPTH        = 4,
   parameter int ALSU_LATENCY = 2,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_opcode,
   input  logic [2:0]               cmd_A,
   input  logic [2:0]               cmd_B,
   input  logic [6:0]               cmd_ctrl,
   input  logic [3:0]               cmd_repeat,
   output logic [2:0]               opcode,
   output logic [2:0]               A,
   output logic [2:0]               B,
   output logic                     cin,
   output logic                     serial_in,
   output logic                     red_op_A,
   output logic                     red_op_B,
   output logic                     bypass_A,
   output logic                     bypass_B,
   output logic                     direction,
   output logic                     issue_valid,
   output logic                     res_valid,
   output logic                     exp_invalid,
   output logic [CNT_W-1:0]         issued_cnt,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = 20;  // {opcode, A, B, ctrl, repeat}

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]          state;
   logic [3:0]          hold_cnt;
   logic [EW-1:0]       mem [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [EW-1:0]       head;
   logic                push, pop, next_issue;
   logic                invalid_now;
   logic [ALSU_LATENCY-1:0] vld_pipe, inv_pipe;

   assign cmd_ready = fifo_count < (PW+1)'(DEPTH);
   assign push      = cmd_valid && cmd_ready && !flush;
   // A held command blocks the pop; flush wins over everything.
   assign pop       = !flush && (hold_cnt == 4'd0) && (fifo_count != '0);
   assign next_issue = !flush && ((hold_cnt != 4'd0) || (fifo_count != '0));
   assign head      = mem[rd_ptr];

   assign issue_valid = (state != S_IDLE);
   assign invalid_now = issue_valid &
                        (((red_op_A | red_op_B) & (opcode[1] | opcode[2])) |
                         (opcode[1] & opcode[2]));

   assign res_valid   = vld_pipe[ALSU_LATENCY-1];
   assign exp_invalid = inv_pipe[ALSU_LATENCY-1];

   // FIFO storage: no reset needed, occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_opcode, cmd_A, cmd_B, cmd_ctrl, cmd_repeat};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // Issue FSM and registered ALSU bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
          bypass_A, bypass_B, direction} <= '0;
      end else if (flush) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
          bypass_A, bypass_B, direction} <= '0;
      end else if (hold_cnt != 4'd0) begin
         state    <= S_HOLD;
         hold_cnt <= hold_cnt - 4'd1;
      end else if (fifo_count != '0) begin
         state    <= S_ISSUE;
         hold_cnt <= head[3:0];
         {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
          bypass_A, bypass_B, direction} <= head[EW-1:4];
      end else begin
         state    <= S_IDLE;
         {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
          bypass_A, bypass_B, direction} <= '0;
      end
   end

   // Counts cycles the bus will carry an op after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              issued_cnt <= '0;
      else if (next_issue && issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
   end

   // Result delay line; keeps draining through flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         inv_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue_valid;
         inv_pipe[0] <= invalid_now;
         for (int i = 1; i < ALSU_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            inv_pipe[i] <= inv_pipe[i-1];
         end
      end
   end

endmodule

// File: doc/alsu_cmd_issuer.md
Name: alsu_cmd_issuer

Overview:
Upstream stage feeding the ALSU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. Each command is driven onto the registered ALSU input bus for 1+cmd_repeat consecutive cycles, so shift/rotate ops can run for several cycles. A delay pipeline matched to the ALSU's 2-cycle latency tells downstream checkers when a result is valid and whether the ALSU should flag it invalid (leds toggle, out=0).

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
ALSU_LATENCY, 2, cycles from issue to ALSU out update; length of res_valid pipeline
CNT_W, 16, width of issued-command counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
flush  in  1  synchronous clear of FIFO, hold counter and outputs
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (count < DEPTH)
cmd_opcode  in  3  ALSU opcode
cmd_A, cmd_B  in  3 each  operands
cmd_ctrl  in  7  {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
cmd_repeat  in  4  extra hold cycles (0..15)
opcode, A, B  out  3 each  registered, to ALSU
cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction  out  1 each  registered, to ALSU
issue_valid  out  1  ALSU bus carries a real op this cycle
res_valid  out  1  ALSU out reflects an issued op
exp_invalid  out  1  that op is invalid per ALSU rules
issued_cnt  out  CNT_W  issue cycles, saturating
fifo_count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst_n=0, async): FIFO empty, hold_cnt=0, every ALSU field 0, issue_valid=0, res_valid=0, exp_invalid=0, issued_cnt=0, fifo_count=0. cmd_ready is combinational (count<DEPTH), so it reads 1 during reset.
- Push when cmd_valid&&cmd_ready on a rising edge. Stores {opcode,A,B,ctrl,repeat}. No push while full. Push and pop on the same edge are allowed when not full, and count is unchanged.
- Three states:
  - IDLE: issue_valid=0, all fields 0.
  - ISSUE: first cycle of a command.
  - HOLD: hold_cnt>0.
- Per edge (priority order):
  - flush: FIFO cleared, hold_cnt=0, fields 0, issue_valid=0 (IDLE). A push in the flush cycle is dropped. Pipeline contents still drain.
  - hold_cnt>0: fields unchanged, issue_valid=1, hold_cnt-1 (HOLD).
  - FIFO non-empty: pop head, drive its fields, hold_cnt=repeat, issue_valid=1 (ISSUE).
  - Otherwise: fields 0, issue_valid=0 (IDLE).
- Minimum latency: a command pushed at edge k is driven after edge k+1, provided the issuer was IDLE.
- Back-to-back commands with repeat=0 produce issue_valid continuously high with no bubble.
- invalid_now = (red_op_A|red_op_B)&(opcode[1]|opcode[2]) | (opcode[1]&opcode[2]), evaluated on the driven fields. It is forced to 0 when issue_valid=0.
- res_valid and exp_invalid are issue_valid and invalid_now each delayed ALSU_LATENCY registers. An op driven after edge t yields res_valid after edge t+2.
- issued_cnt increments on every edge where issue_valid becomes or stays 1. It saturates at all-ones.
- fifo_count is the registered occupancy. No wrap on pointers beyond DEPTH entries.
- rst_n asserted mid-HOLD aborts everything immediately. There is no resumption.

Test Plan:
- Reset during HOLD (repeat=9, 3 cycles in), rst_n low 1 cycle -> all outputs 0 at once, fifo_count=0, cmd_ready=1. Next pushed cmd issues normally.
- Push opcode=010 A=3 B=2 cin=1 repeat=0 at edge 0 -> fields driven after edge 1 for exactly 1 cycle, issue_valid pulse 1 cycle, res_valid pulse after edge 3, exp_invalid=0, issued_cnt=1.
- Push opcode=100 direction=1 repeat=5, then opcode=001 repeat=0 -> opcode=100 held 6 cycles (issue_valid high throughout), then opcode=001 for 1 cycle with no gap, then IDLE zeros. issued_cnt=7.
- Holding cmd_valid=1 while first cmd has repeat=15 -> cmd_ready falls when fifo_count=4 (DEPTH=4). No entry lost or duplicated. Order preserved on drain.
- Invalid checks:
  - opcode=111 -> exp_invalid=1 aligned with its res_valid.
  - red_op_A=1 with opcode=011 -> exp_invalid=1.
  - red_op_B=1 with opcode=001 -> exp_invalid=0.
- flush during HOLD with 3 queued entries -> next edge fields 0, issue_valid=0, fifo_count=0. In-flight res_valid still appears 2 cycles later. Simultaneous push is discarded.
